// File: rtl/data_mem_arbiter.sv
//==============================================================================
// Module  : data_mem_arbiter
// Brief   : Round-robin arbiter with bounded lock for a shared byte-wide
//           single-port data memory (port 0 = LSU, port 1 = DMA loader).
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int W       = 8,
  parameter int A       = 8,
  parameter int MAXLOCK = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic         Req1,
  input  logic         We0,
  input  logic         We1,
  input  logic [A-1:0] Addr0,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] Wdata0,
  input  logic [W-1:0] Wdata1,
  input  logic         Lock0,
  input  logic         Lock1,
  output logic         Gnt0,
  output logic         Gnt1,
  output logic         Rvalid0,
  output logic         Rvalid1,
  output logic [W-1:0] Rdata0,
  output logic [W-1:0] Rdata1,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  localparam int                   c_CNT_W    = $clog2(MAXLOCK);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(MAXLOCK - 1);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_LOCK0 = 2'd1,
    OWN_LOCK1 = 2'd2
  } own_t;

  own_t               r_own;
  logic               r_last;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_rvalid0;
  logic               r_rvalid1;
  logic [W-1:0]       r_rdata0;
  logic [W-1:0]       r_rdata1;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_gnt_any;
  logic               w_gnt_port;
  logic               w_gnt_lock;
  own_t               w_own_g;

  // A lock only binds while its owner keeps requesting; otherwise plain round robin.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (Reset) begin
      if (r_own == OWN_LOCK0 && Req0) begin
        w_gnt0 = 1'b1;
      end else if (r_own == OWN_LOCK1 && Req1) begin
        w_gnt1 = 1'b1;
      end else if (Req0 && Req1) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = Req0;
        w_gnt1 = Req1;
      end
    end
  end

  assign w_gnt_any  = w_gnt0 | w_gnt1;
  assign w_gnt_port = w_gnt1;
  assign w_gnt_lock = w_gnt1 ? Lock1 : Lock0;
  assign w_own_g    = w_gnt1 ? OWN_LOCK1 : OWN_LOCK0;

  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (w_gnt0) begin
      MemWriteEn = We0;
      MemAddress = Addr0;
      MemDataIn  = Wdata0;
    end else if (w_gnt1) begin
      MemWriteEn = We1;
      MemAddress = Addr1;
      MemDataIn  = Wdata1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_own     <= OWN_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 && !We0;
      r_rvalid1 <= w_gnt1 && !We1;
      if (w_gnt0 && !We0) r_rdata0 <= MemDataOut;
      if (w_gnt1 && !We1) r_rdata1 <= MemDataOut;

      if (w_gnt_any) begin
        r_last <= w_gnt_port;
        if (!w_gnt_lock) begin
          r_own <= OWN_IDLE;
          r_cnt <= '0;
        end else if (r_own == w_own_g) begin
          // Forced release after MAXLOCK consecutive grants bounds starvation.
          if (r_cnt == c_CNT_LAST) begin
            r_own <= OWN_IDLE;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end else begin
          r_own <= w_own_g;
          r_cnt <= c_CNT_ONE;
        end
      end else if (r_own != OWN_IDLE) begin
        r_own <= OWN_IDLE;
        r_cnt <= '0;
      end
    end
  end

  assign Gnt0    = w_gnt0;
  assign Gnt1    = w_gnt1;
  assign Rvalid0 = r_rvalid0;
  assign Rvalid1 = r_rvalid1;
  assign Rdata0  = r_rdata0;
  assign Rdata1  = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
//==============================================================================
// Module  : tb_data_mem_arbiter
// Brief   : Directed scoreboard bench for data_mem_arbiter with a byte memory.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_data_mem_arbiter;

  logic       Clk;
  logic       Reset;
  logic       Req0, Req1, We0, We1, Lock0, Lock1;
  logic [7:0] Addr0, Addr1, Wdata0, Wdata1;
  logic       Gnt0, Gnt1, Rvalid0, Rvalid1;
  logic [7:0] Rdata0, Rdata1;
  logic       MemWriteEn;
  logic [7:0] MemAddress, MemDataIn, MemDataOut;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       init_done;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] exp_rd0, exp_rd1;

  int total;
  int passed;

  data_mem_arbiter #(.W(8), .A(8), .MAXLOCK(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Lock0(Lock0), .Lock1(Lock1), .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Rvalid0(Rvalid0), .Rvalid1(Rvalid1), .Rdata0(Rdata0), .Rdata1(Rdata1),
    .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] init_val(input int i);
    return (i == 'h30) ? 8'h07 : (8'(i) ^ 8'hC3);
  endfunction

  // Single-port memory with combinational read, preloaded before use.
  assign MemDataOut = mem[MemAddress];
  always @(posedge Clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (MemWriteEn) begin
      mem[MemAddress] <= MemDataIn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are already set (at negedge); check grant/memory drive, then read return.
  task automatic do_cycle(input string tag, input logic g0, input logic g1);
    #1;
    chk({tag, " gnt0"}, 32'(Gnt0), 32'(g0));
    chk({tag, " gnt1"}, 32'(Gnt1), 32'(g1));
    if (g0) begin
      chk({tag, " addr"}, 32'(MemAddress), 32'(Addr0));
      chk({tag, " we"}, 32'(MemWriteEn), 32'(We0));
      if (We0) begin
        chk({tag, " din"}, 32'(MemDataIn), 32'(Wdata0));
        ref_mem[Addr0] = Wdata0;
      end else q0.push_back(ref_mem[Addr0]);
    end else if (g1) begin
      chk({tag, " addr"}, 32'(MemAddress), 32'(Addr1));
      chk({tag, " we"}, 32'(MemWriteEn), 32'(We1));
      if (We1) begin
        chk({tag, " din"}, 32'(MemDataIn), 32'(Wdata1));
        ref_mem[Addr1] = Wdata1;
      end else q1.push_back(ref_mem[Addr1]);
    end else begin
      chk({tag, " idle we"}, 32'(MemWriteEn), 32'd0);
      chk({tag, " idle addr"}, 32'(MemAddress), 32'd0);
    end
    @(posedge Clk);
    #1;
    chk({tag, " rvalid0"}, 32'(Rvalid0), 32'(g0 && !We0));
    chk({tag, " rvalid1"}, 32'(Rvalid1), 32'(g1 && !We1));
    if (g0 && !We0 && q0.size() > 0) exp_rd0 = q0.pop_front();
    if (g1 && !We1 && q1.size() > 0) exp_rd1 = q1.pop_front();
    chk({tag, " rdata0"}, 32'(Rdata0), 32'(exp_rd0));
    chk({tag, " rdata1"}, 32'(Rdata1), 32'(exp_rd1));
    @(negedge Clk);
  endtask

  task automatic set0(input logic req, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input logic lk);
    Req0 = req; We0 = we; Addr0 = a; Wdata0 = d; Lock0 = lk;
  endtask

  task automatic set1(input logic req, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input logic lk);
    Req1 = req; We1 = we; Addr1 = a; Wdata1 = d; Lock1 = lk;
  endtask

  initial begin
    total = 0; passed = 0;
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    init_done = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    Reset = 1'b0;
    set0(1'b1, 1'b1, 8'h10, 8'hAA, 1'b0);
    set1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state with a write request pending.
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    init_done = 1'b1;
    #1;
    chk("rst gnt0", 32'(Gnt0), 32'd0);
    chk("rst we", 32'(MemWriteEn), 32'd0);
    chk("rst addr", 32'(MemAddress), 32'd0);
    chk("rst rvalid0", 32'(Rvalid0), 32'd0);
    chk("rst rdata0", 32'(Rdata0), 32'd0);
    chk("rst rdata1", 32'(Rdata1), 32'd0);
    @(negedge Clk);

    // Reset pulsed mid-cycle cancels the write.
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("midrst gnt0", 32'(Gnt0), 32'd0);
    chk("midrst we", 32'(MemWriteEn), 32'd0);
    @(posedge Clk); #1;
    chk("midrst mem10", 32'(mem[8'h10]), 32'(init_val('h10)));
    @(negedge Clk);
    Reset = 1'b1;
    set0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    set1(1'b1, 1'b0, 8'h11, 8'h00, 1'b0);
    do_cycle("first", 1'b1, 1'b0);
    set0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_cycle("second", 1'b0, 1'b1);

    // Write then read-after-write on port 0.
    set1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set0(1'b1, 1'b1, 8'h20, 8'h5A, 1'b0);
    do_cycle("raw wr", 1'b1, 1'b0);
    set0(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    do_cycle("raw rd", 1'b1, 1'b0);
    chk("raw data", 32'(Rdata0), 32'h5A);
    set0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set1(1'b1, 1'b0, 8'h21, 8'h00, 1'b0);
    do_cycle("solo1", 1'b0, 1'b1);

    // Continuous contention without lock alternates 0,1,...
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, 1'b0, 8'(8'h40 + i), 8'h00, 1'b0);
      set1(1'b1, 1'b0, 8'(8'h50 + i), 8'h00, 1'b0);
      do_cycle("rr", (i % 2) == 0, (i % 2) == 1);
    end

    // Port 1 locked read-modify-write while port 0 keeps requesting.
    set1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set0(1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
    do_cycle("pre rmw", 1'b1, 1'b0);
    set1(1'b1, 1'b0, 8'h30, 8'h00, 1'b1);
    do_cycle("rmw rd", 1'b0, 1'b1);
    chk("rmw rdval", 32'(Rdata1), 32'h07);
    set1(1'b1, 1'b1, 8'h30, 8'h08, 1'b0);
    do_cycle("rmw wr", 1'b0, 1'b1);
    set1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_cycle("rmw after", 1'b1, 1'b0);
    chk("rmw mem30", 32'(mem[8'h30]), 32'h08);

    // Bounded lock: four grants to port 0, then port 1, then port 0 relocks.
    set0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set1(1'b1, 1'b0, 8'h60, 8'h00, 1'b0);
    do_cycle("pre lock", 1'b0, 1'b1);
    set0(1'b1, 1'b0, 8'h61, 8'h00, 1'b1);
    set1(1'b1, 1'b0, 8'h62, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle("lock0", 1'b1, 1'b0);
    do_cycle("lock brk", 1'b0, 1'b1);
    do_cycle("relock", 1'b1, 1'b0);

    // Owner drops its request: the other port is granted in the same cycle.
    set0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_cycle("lock drop", 1'b0, 1'b1);
    set1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_cycle("idle", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port, byte-wide data memory between two requesters: port 0 is the processor load/store unit, port 1 is the test/DMA loader.
- Grants at most one access per cycle using round-robin priority.
- Supports a bounded lock, so a requester can do an atomic read-modify-write.
- Drives the memory's WriteEn/DataAddress/DataIn directly and captures its combinational read data into per-port registers.

Parameters:
W, 8, data width; must match the data memory.
A, 8, address width; must match the data memory.
MAXLOCK, 4, maximum consecutive grants one locked requester may hold (≥2).

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
Req0/Req1  in  1  access request; held stable with We/Addr/Wdata/Lock until granted.
We0/We1  in  1  1 = write, 0 = read.
Addr0/Addr1  in  A  memory address.
Wdata0/Wdata1  in  W  write data.
Lock0/Lock1  in  1  keep ownership after this grant.
Gnt0/Gnt1  out  1  combinational; access issues this cycle.
Rvalid0/Rvalid1  out  1  registered; read data valid, one cycle after a granted read.
Rdata0/Rdata1  out  W  registered read data; holds its value until the next read on that port.
MemWriteEn  out  1  to the memory WriteEn.
MemAddress  out  A  to the memory DataAddress.
MemDataIn  out  W  to the memory DataIn.
MemDataOut  in  W  from the memory DataOut (combinational read).

Behaviour:
- State register holds:
  - Own ∈ {IDLE, LOCK0, LOCK1}.
  - Last, the last granted port (1 bit).
  - LockCnt, ceil(log2 MAXLOCK) bits.
- While Reset=0:
  - Own=IDLE, Last=1 (port 0 is favoured first), LockCnt=0.
  - Rvalid0/1=0, Rdata0/1=0.
  - Gnt0/1=0 and MemWriteEn=0, both forced combinationally.
  - Reset asserted mid-access cancels the access; no write commits.
- Grant selection is combinational each cycle:
  - IDLE, single requester: grant it.
  - IDLE, both requesting: grant port !Last.
  - LOCKi with Req_i=1: grant i only; the other port gets Gnt=0 even if requesting.
  - LOCKi with Req_i=0: treat the cycle as IDLE and arbitrate normally.
- Gnt0 and Gnt1 are never both 1.
- Memory drive:
  - Granted port: MemAddress=Addr_g, MemDataIn=Wdata_g, MemWriteEn=We_g.
  - No grant: MemAddress=0, MemDataIn=0, MemWriteEn=0.
- Latency:
  - A write commits at the posedge ending the grant cycle.
  - A read samples MemDataOut at that posedge; Rdata_g is updated and Rvalid_g=1 for exactly one cycle.
  - A read of the same address granted the cycle after a write returns the new data.
- Back-to-back grants to the same port are allowed; Rvalid may then stay high for consecutive cycles.
- Requester protocol: after Gnt_i=1 the request is consumed. Keeping Req_i high the next cycle is a new request.
- On posedge with a grant to port g: Last<=g.
- Lock transitions, applied on the posedge of a cycle granted to port g:
  - Lock_g=1 and Own=IDLE (or LOCK cleared this cycle): Own<=LOCKg, LockCnt<=1.
  - Own=LOCKg, Lock_g=1, LockCnt<MAXLOCK-1: LockCnt<=LockCnt+1, stay.
  - Own=LOCKg and (Lock_g=0 or LockCnt==MAXLOCK-1): Own<=IDLE, LockCnt<=0. The other port wins the next contended cycle because Last=g.
  - Own=LOCKg with no grant (Req_g=0): Own<=IDLE, LockCnt<=0.
- A locked requester therefore receives at most MAXLOCK consecutive grants, which bounds starvation.
- No grant, no lock: all state holds except Rvalid0/1<=0.
- Unknown or X inputs on a non-requesting port must not affect the outputs.

Test Plan:
1. Reset=0 pulsed mid-cycle while Req0=1, We0=1, Addr0=8'h10, Wdata0=8'hAA -> Gnt0=0, MemWriteEn=0, mem[0x10] unchanged; after release, first grant goes to port 0.
2. Port 0 writes 8'h5A to 0x20, then reads 0x20 the next cycle -> Gnt0 in both cycles; Rvalid0=1 one cycle after the read; Rdata0=8'h5A.
3. Both request continuously, Lock=0, for 6 cycles -> grants alternate 0,1,0,1,0,1; never both Gnt high; each read returns the correct data to the owning port only.
4. Port 1 reads 0x30 (=8'h07) with Lock1=1, then writes 8'h08 with Lock1=0, while Req0=1 throughout -> Gnt1 for 2 consecutive cycles, Gnt0 in cycle 3; mem[0x30]=8'h08.
5. Port 0 holds Lock0=1 and Req0=1 indefinitely, Req1=1, MAXLOCK=4 -> Gnt0 for 4 cycles, Gnt1 in cycle 5, then Gnt0 relocks.
6. Own=LOCK0 and Req0 drops while Req1=1 -> Gnt1 in that same cycle; Own returns to IDLE.
